booth_wallace_multiplier: RTL and testbench

//   Signed two's-complement multiplier for the vector datapath lanes.

---
 rtl/booth_wallace_pkg.sv | 43 ++++
 rtl/booth_wallace_multiplier_pp_gen.sv | 40 ++++
 rtl/booth_wallace_multiplier.sv | 116 +++++++++++
 tb/tb_booth_wallace_multiplier.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_wallace_pkg.sv
// Shared types and elaboration-time helpers for the Booth/Wallace multiplier.
package booth_wallace_pkg;

  typedef enum logic [2:0] {ZERO, POS1, POS2, NEG1, NEG2} booth_digit_t;

  function automatic booth_digit_t booth_decode(logic [2:0] triplet);
    booth_digit_t digit;
    case (triplet)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
    return digit;
  endfunction

  function automatic int unsigned num_pp(int unsigned w);
    return w / 2;
  endfunction

  // Rows left after one level of 3:2 compression.
  function automatic int unsigned next_rows(int unsigned n);
    return 2 * (n / 3) + n % 3;
  endfunction

  function automatic int unsigned rows_at(int unsigned n, int unsigned lvl);
    int unsigned r = n;
    for (int unsigned i = 0; i < lvl; i++) r = next_rows(r);
    return r;
  endfunction

  function automatic int unsigned num_levels(int unsigned n);
    int unsigned r = n;
    int unsigned l = 0;
    while (r > 2) begin
      r = next_rows(r);
      l++;
    end
    return l;
  endfunction

endpackage

// File: rtl/booth_wallace_multiplier_pp_gen.sv
// One radix-4 Booth partial-product row, already shifted into place and sign-extended.
module booth_pp_gen
  import booth_wallace_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHIFT = 0
) (
  input  logic [2:0]         triplet,
  input  logic [WIDTH-1:0]   a,
  output logic [2*WIDTH-1:0] row,
  output logic               neg
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] mag;

  assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};

  // Negative digits emit only the inverted magnitude; the +1 at bit SHIFT
  // is injected into the tree through neg.
  always_comb begin
    mag = '0;
    neg = 1'b0;
    case (booth_decode(triplet))
      POS1: mag = a_ext;
      POS2: mag = a_ext << 1;
      NEG1: begin
        mag = ~a_ext;
        neg = 1'b1;
      end
      NEG2: begin
        mag = ~(a_ext << 1);
        neg = 1'b1;
      end
      default: mag = '0;
    endcase
    row = mag << SHIFT;
  end

endmodule

// File: rtl/booth_wallace_multiplier.sv
// Signed radix-4 Booth / Wallace-tree multiplier with a registered product.
// Define BOOTH_WALLACE_PIPE_EN to register the reduced rows (latency 2 instead of 1).
module booth_wallace_multiplier
  import booth_wallace_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned NPP    = num_pp(WIDTH);
  localparam int unsigned NR     = NPP + 1;
  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned LEVELS = num_levels(NR);

  if (WIDTH < 4 || WIDTH % 2 != 0) begin : g_bad_width
    $error("booth_wallace_multiplier: WIDTH must be even and >= 4");
  end

  logic [WIDTH:0]  b_ext;
  logic [NPP-1:0]  neg;
  logic [PW-1:0]   corr;
  logic [PW-1:0]   pp_rows [NR];

  assign b_ext = {multiplier, 1'b0};

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    booth_pp_gen #(
      .WIDTH (WIDTH),
      .SHIFT (2 * i)
    ) u_pp (
      .triplet (b_ext[2*i+2:2*i]),
      .a       (multiplicand),
      .row     (pp_rows[i]),
      .neg     (neg[i])
    );
  end

  // Negation carries land on distinct even bits, so they share one extra row.
  always_comb begin
    corr = '0;
    for (int i = 0; i < NPP; i++) corr[2*i] = neg[i];
  end
  assign pp_rows[NPP] = corr;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int unsigned NIN  = rows_at(NR, l);
    localparam int unsigned NGRP = NIN / 3;
    localparam int unsigned NOUT = next_rows(NIN);
    logic [PW-1:0] src [NIN];
    logic [PW-1:0] dst [NOUT];

    if (l == 0) begin : g_first
      assign src = pp_rows;
    end else begin : g_next
      assign src = g_lvl[l-1].dst;
    end

    for (genvar g = 0; g < NGRP; g++) begin : g_csa
      assign dst[2*g]   = src[3*g] ^ src[3*g+1] ^ src[3*g+2];
      assign dst[2*g+1] = ((src[3*g] & src[3*g+1]) | (src[3*g] & src[3*g+2]) |
                           (src[3*g+1] & src[3*g+2])) << 1;
    end

    for (genvar j = 0; j < NIN % 3; j++) begin : g_pass
      assign dst[2*NGRP+j] = src[3*NGRP+j];
    end
  end

  logic [PW-1:0] row_a;
  logic [PW-1:0] row_b;
  logic          stage_valid;

`ifdef BOOTH_WALLACE_PIPE_EN
  logic [PW-1:0] row_a_q;
  logic [PW-1:0] row_b_q;
  logic          valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_a_q <= '0;
      row_b_q <= '0;
      valid_q <= 1'b0;
    end else begin
      row_a_q <= g_lvl[LEVELS-1].dst[0];
      row_b_q <= g_lvl[LEVELS-1].dst[1];
      valid_q <= in_valid;
    end
  end

  assign row_a       = row_a_q;
  assign row_b       = row_b_q;
  assign stage_valid = valid_q;
`else
  assign row_a       = g_lvl[LEVELS-1].dst[0];
  assign row_b       = g_lvl[LEVELS-1].dst[1];
  assign stage_valid = in_valid;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= stage_valid;
      if (stage_valid) product <= row_a + row_b;
    end
  end

endmodule

// File: tb/tb_booth_wallace_multiplier.sv
// Self-checking bench: WIDTH 8/4/16 instances share clk, rst and in_valid.
module tb_booth_wallace_multiplier;

`ifdef BOOTH_WALLACE_PIPE_EN
  localparam int L = 2;
`else
  localparam int L = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        ov8, ov4, ov16;
  logic [15:0] p8;
  logic [7:0]  p4;
  logic [31:0] p16;

  always #5 clk = ~clk;

  booth_wallace_multiplier #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .multiplicand(a8), .multiplier(b8),
    .out_valid(ov8), .product(p8)
  );
  booth_wallace_multiplier #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .multiplicand(a4), .multiplier(b4),
    .out_valid(ov4), .product(p4)
  );
  booth_wallace_multiplier #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .multiplicand(a16), .multiplier(b16),
    .out_valid(ov16), .product(p16)
  );

  // Reference: products from plain signed arithmetic, delayed through a queue of depth L.
  typedef struct {
    logic   v;
    longint p8;
    longint p4;
    longint p16;
  } ent_t;

  ent_t   q[$];
  logic   m_v = 1'b0;
  longint m_p8 = 0, m_p4 = 0, m_p16 = 0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    ent_t e;
    @(posedge clk);
    #1;
    if (rst) begin
      q.delete();
      m_v = 1'b0;
      m_p8 = 0;
      m_p4 = 0;
      m_p16 = 0;
    end else begin
      e.v   = in_valid;
      e.p8  = longint'($signed(a8)) * longint'($signed(b8));
      e.p4  = longint'($signed(a4)) * longint'($signed(b4));
      e.p16 = longint'($signed(a16)) * longint'($signed(b16));
      q.push_back(e);
      if (q.size() == L) begin
        e = q.pop_front();
        m_v = e.v;
        if (e.v) begin
          m_p8  = e.p8;
          m_p4  = e.p4;
          m_p16 = e.p16;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, "_ov8"},  longint'(ov8),  longint'(m_v));
    check_val({tag, "_ov4"},  longint'(ov4),  longint'(m_v));
    check_val({tag, "_ov16"}, longint'(ov16), longint'(m_v));
    check_val({tag, "_p8"},   longint'($signed(p8)),  m_p8);
    check_val({tag, "_p4"},   longint'($signed(p4)),  m_p4);
    check_val({tag, "_p16"},  longint'($signed(p16)), m_p16);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{a: 8'h00, b: 8'h00, exp: 16'h0000};
    vecs[1] = '{a: 8'hFF, b: 8'hFF, exp: 16'h0001};
    vecs[2] = '{a: 8'h01, b: 8'hFF, exp: 16'hFFFF};
    vecs[3] = '{a: 8'h80, b: 8'h80, exp: 16'h4000};
    vecs[4] = '{a: 8'h7F, b: 8'h80, exp: 16'hC080};
    vecs[5] = '{a: 8'h7F, b: 8'h7F, exp: 16'h3F01};

    // Reset held two cycles with live operands.
    rst = 1'b1;
    in_valid = 1'b1;
    a8 = 8'd5; b8 = 8'd3; a4 = 4'd2; b4 = 4'd3; a16 = 16'd100; b16 = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("rst_p8", longint'(p8), 0);
      check_val("rst_ov8", longint'(ov8), 0);
      check_all("rst");
    end
    rst = 1'b0;
    step();
    in_valid = 1'b0;
    for (int i = 1; i < L; i++) step();
    check_val("post_rst_p8", longint'(p8), 15);
    check_all("post_rst");

    // Edge values from the table.
    foreach (vecs[i]) begin
      a8 = vecs[i].a;
      b8 = vecs[i].b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int k = 1; k < L; k++) step();
      check_val($sformatf("edge%0d_p8", i), longint'(p8), longint'(vecs[i].exp));
      check_val($sformatf("edge%0d_ov8", i), longint'(ov8), 1);
      check_all("edge");
    end

    // Most negative operands at WIDTH=4 and WIDTH=16.
    a4 = 4'b1000; b4 = 4'b1000; a16 = 16'h8000; b16 = 16'h8000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k < L; k++) step();
    check_val("w4_min_sq", longint'(p4), 64);
    check_val("w16_min_sq", longint'(p16), 64'h4000_0000);
    check_all("min_sq");

    // Back-to-back random operands.
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom);
      a4 = 4'($urandom); b4 = 4'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
      in_valid = 1'b1;
      step();
      check_all("rand");
    end

    // Valid gaps: 1,0,1,1,0 then drain.
    begin
      logic [4:0] pat;
      pat = 5'b01101;
      for (int i = 0; i < 5 + L; i++) begin
        a8 = 8'($urandom); b8 = 8'($urandom);
        a4 = 4'($urandom); b4 = 4'($urandom);
        a16 = 16'($urandom); b16 = 16'($urandom);
        in_valid = (i < 5) ? pat[i] : 1'b0;
        step();
        check_all("gap");
      end
    end

    // Mid-stream reset with two ops in flight.
    a8 = 8'd11; b8 = 8'd13; in_valid = 1'b1;
    step();
    a8 = 8'hF0; b8 = 8'd9;
    step();
    rst = 1'b1;
    step();
    check_val("mid_rst_ov8", longint'(ov8), 0);
    check_all("mid_rst");
    rst = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < L; i++) begin
      step();
      check_val("mid_rst_drain_ov8", longint'(ov8), 0);
      check_all("mid_rst_drain");
    end
    a8 = 8'd3; b8 = 8'd7; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 1; k < L; k++) step();
    check_val("after_rst_3x7", longint'(p8), 21);
    check_val("after_rst_ov8", longint'(ov8), 1);
    check_all("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
